sum_unit: RTL and testbench
===========================

Name: sum_unit

Overview:
- Parameterised unsigned binary adder with carry-in and carry-out.
- Used as the mantissa adder in the floating-point datapath; default 28 bits covers the aligned mantissa plus guard/round/sticky bits.
- Provides a zero-latency combinational result and a registered copy of that result, one cycle later, for pipelined consumers.

Parameters:
SIZE_DATA, 28, operand and sum width in bits; legal range 1..64.

Ports:
i_clk  input  1  clock; all registers update on rising edge
i_rst  input  1  synchronous reset, active-high
i_carry  input  1  carry-in, weight 2^0
i_data_a  input  SIZE_DATA  operand A, unsigned
i_data_b  input  SIZE_DATA  operand B, unsigned
o_sum  output  SIZE_DATA  combinational sum, low SIZE_DATA bits of A+B+Cin
o_carry  output  1  combinational carry-out, bit SIZE_DATA of A+B+Cin
o_sum_q  output  SIZE_DATA  o_sum registered, 1-cycle latency
o_carry_q  output  1  o_carry registered, 1-cycle latency

Behaviour:
- Arithmetic: {o_carry, o_sum} = zero-extend(A) + zero-extend(B) + Cin, computed at SIZE_DATA+1 bits. The result is exact and never saturates.
- Combinational path:
  - o_sum and o_carry depend only on i_data_a, i_data_b and i_carry; they contain no state.
  - They are valid within the same delta or settle time, independent of i_clk and i_rst.
- Structure:
  - Carry-lookahead in 4-bit groups: per-bit generate g=a&b and propagate p=a^b.
  - Group carries are computed by lookahead equations and rippled between groups.
  - A final partial group is handled when SIZE_DATA is not a multiple of 4.
  - sum bit = p ^ carry-in of that bit. Do not use a single behavioural '+' for the datapath.
- Registered path:
  - On each rising i_clk with i_rst=1: o_sum_q <= 0, o_carry_q <= 0.
  - On each rising i_clk with i_rst=0: o_sum_q <= o_sum, o_carry_q <= o_carry.
  - No enable; a new result is captured every cycle.
- Reset mid-operation: only the registered outputs clear. The combinational outputs keep tracking the inputs.
- Boundaries:
  - All-ones + 0 + Cin=1 wraps o_sum to 0 with o_carry=1.
  - All-ones + all-ones + 1 gives o_sum = all-ones, o_carry=1.
  - 0+0+0 gives 0 and carry 0.
- Inputs that are X or Z produce unspecified outputs. No internal sanitising is performed.

Optional Feature:
- Macro: SUM_UNIT_FLAGS_EN.
- When defined, three extra outputs are added:
  - o_zero (1 bit): 1 when o_sum == 0, combinational.
  - o_zero_q (1 bit): o_zero registered, reset to 1.
  - o_ovf (1 bit): signed two's-complement overflow of A+B+Cin = carry into MSB XOR carry out of MSB, combinational.
- When undefined, these ports and their logic do not exist. All other behaviour is identical in both builds.

Test Plan:
- A=0000000, B=0000000, Cin=0 -> o_sum=0000000, o_carry=0; o_sum_q=0 after next edge.
- A=FFFFFFF, B=0000000, Cin=1 -> o_sum=0000000, o_carry=1 (full ripple across all groups).
- A=FFFFFFF, B=FFFFFFF, Cin=1 -> o_sum=FFFFFFF, o_carry=1.
- A=1234567, B=0ABCDEF, Cin=0 -> o_sum=1CF1356, o_carry=0.
- Registered path and reset:
  - Apply A=8000000, B=8000000, Cin=0 -> o_sum=0000000, o_carry=1 immediately.
  - o_sum_q/o_carry_q show these values one edge later.
  - Assert i_rst for one edge -> o_sum_q=0, o_carry_q=0 while o_sum/o_carry stay unchanged.
- 500 random A, B, Cin vectors -> every vector matches the (SIZE_DATA+1)-bit reference sum, combinationally and on the registered outputs one cycle delayed.

Source files
------------

// File: rtl/sum_unit.sv
// Unsigned adder, 4-bit carry-lookahead groups, combinational and registered result.
// Optional zero/overflow flags are built when SUM_UNIT_FLAGS_EN is defined.
module sum_unit #(
  parameter int SIZE_DATA = 28
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_carry,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic [SIZE_DATA-1:0] o_sum,
  output logic                 o_carry,
`ifdef SUM_UNIT_FLAGS_EN
  output logic                 o_zero,
  output logic                 o_zero_q,
  output logic                 o_ovf,
`endif
  output logic [SIZE_DATA-1:0] o_sum_q,
  output logic                 o_carry_q
);

  logic [SIZE_DATA-1:0] g;
  logic [SIZE_DATA-1:0] p;
  logic [SIZE_DATA:0]   c;

  assign g = i_data_a & i_data_b;
  assign p = i_data_a ^ i_data_b;

  // Each bit carry is a flat lookahead term from its group's carry-in;
  // only the group carry-out ripples on to the next group.
  always_comb begin
    int   gb;
    logic t;
    logic pp;
    gb   = 0;
    t    = 1'b0;
    pp   = 1'b0;
    c    = '0;
    c[0] = i_carry;
    for (int i = 0; i < SIZE_DATA; i++) begin
      gb = i - (i % 4);
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= gb; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & c[gb]);
    end
  end

  assign o_sum   = p ^ c[SIZE_DATA-1:0];
  assign o_carry = c[SIZE_DATA];

  logic [SIZE_DATA-1:0] sum_d, sum_q;
  logic                 carry_d, carry_q;

  always_comb begin
    sum_d   = o_sum;
    carry_d = o_carry;
    if (i_rst) begin
      sum_d   = '0;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    sum_q   <= sum_d;
    carry_q <= carry_d;
  end

  assign o_sum_q   = sum_q;
  assign o_carry_q = carry_q;

`ifdef SUM_UNIT_FLAGS_EN
  logic zero_d, zero_q;

  assign o_zero = (o_sum == '0);
  assign o_ovf  = c[SIZE_DATA-1] ^ c[SIZE_DATA];
  assign zero_d = i_rst ? 1'b1 : o_zero;

  always_ff @(posedge i_clk) begin
    zero_q <= zero_d;
  end

  assign o_zero_q = zero_q;
`endif

endmodule

// File: tb/tb_sum_unit.sv
// Scoreboard bench for sum_unit: driver checks the combinational result,
// monitor pops expected registered results one edge later.
module tb_sum_unit;

  localparam int W = 28;
  localparam logic [W-1:0] ONES = '1;

  logic         clk;
  logic         rst;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic [W-1:0] sum_q;
  logic         cout_q;
`ifdef SUM_UNIT_FLAGS_EN
  logic         zero;
  logic         zero_q;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // entry = {zero, carry, sum}
  logic [W+1:0] exp_q[$];
  bit           done = 0;

  sum_unit #(.SIZE_DATA(W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_carry  (cin),
    .i_data_a (a),
    .i_data_b (b),
    .o_sum    (sum),
    .o_carry  (cout),
`ifdef SUM_UNIT_FLAGS_EN
    .o_zero   (zero),
    .o_zero_q (zero_q),
    .o_ovf    (ovf),
`endif
    .o_sum_q  (sum_q),
    .o_carry_q(cout_q)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic apply(input string nm,
                       input logic [W-1:0] va,
                       input logic [W-1:0] vb,
                       input logic vc,
                       input logic vr,
                       input logic [W-1:0] es,
                       input logic ec);
    logic eo;
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    rst = vr;
    #1;
    checks++;
    if (sum !== es || cout !== ec) begin
      errors++;
      $display("FAIL %s comb: got c=%b s=%h want c=%b s=%h",
               nm, cout, sum, ec, es);
    end
`ifdef SUM_UNIT_FLAGS_EN
    eo = (va[W-1] == vb[W-1]) && (es[W-1] != va[W-1]);
    checks++;
    if (zero !== (es == '0) || ovf !== eo) begin
      errors++;
      $display("FAIL %s flags: got z=%b o=%b want z=%b o=%b",
               nm, zero, ovf, (es == '0), eo);
    end
`else
    eo = 1'b0;
`endif
    if (vr) exp_q.push_back({1'b1, 1'b0, {W{1'b0}}});
    else    exp_q.push_back({(es == '0), ec, es});
  endtask

  // Monitor: registered outputs reflect the vector applied before this edge
  always @(posedge clk) begin
    logic [W+1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (sum_q !== e[W-1:0] || cout_q !== e[W]) begin
        errors++;
        $display("FAIL reg: got c=%b s=%h want c=%b s=%h",
                 cout_q, sum_q, e[W], e[W-1:0]);
      end
`ifdef SUM_UNIT_FLAGS_EN
      checks++;
      if (zero_q !== e[W+1]) begin
        errors++;
        $display("FAIL reg_zero: got %b want %b", zero_q, e[W+1]);
      end
`endif
    end
  end

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc;
    logic [W:0]   full;
    a   = '0;
    b   = '0;
    cin = 0;
    rst = 1;
    apply("reset",  '0, '0, 0, 1, '0, 0);
    apply("zero",   '0, '0, 0, 0, '0, 0);
    apply("wrap",   ONES, '0, 1, 0, '0, 1);
    apply("ones",   ONES, ONES, 1, 0, ONES, 1);
    apply("mix",    28'h1234567, 28'h0ABCDEF, 0, 0, 28'h1CF1356, 0);
    apply("msb",    28'h8000000, 28'h8000000, 0, 0, '0, 1);
    apply("rst_mid", 28'h8000000, 28'h8000000, 0, 1, '0, 1);
    apply("post_rst", 28'h0000001, 28'h000000F, 1, 0, 28'h0000011, 0);
    apply("grp",    28'h000FFFF, 28'h0000001, 0, 0, 28'h0010000, 0);
    apply("ovf",    28'h7FFFFFF, 28'h0000000, 1, 0, 28'h8000000, 0);
    for (int i = 0; i < 500; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      es   = full[W-1:0];
      apply("rand", ra, rb, rc, 0, es, full[W]);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left want 0", exp_q.size());
    end
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: run did not finish");
      $fatal(1);
    end
  end

endmodule
